// File: rtl/ram_operand_sequencer_pkg.sv
// Shared types and defaults for the operand-RAM sequencer: state encoding,
// default widths and the address legality helper.
package ram_operand_sequencer_pkg;

  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 6;
  localparam int DEPTH_N = 48;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_ISSUE, S_WAIT, S_WB, S_DONE, S_ERR
  } state_e;

  function automatic logic addr_ok(input int a, input int depth);
    return a < depth;
  endfunction

endpackage

// File: rtl/ram_operand_sequencer_if.sv
// Bundle of command, dual-port RAM and multiplier handshake signals.
// master = sequencer side, slave = environment (RAM, multiplier, control FSM).
interface ram_operand_sequencer_if #(
  parameter int DATA = 256,
  parameter int ADDR = 6
);
  logic            cmd_valid, cmd_ready;
  logic [ADDR-1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic            ram_a_w, ram_b_w;
  logic [ADDR-1:0] ram_a_adbus, ram_b_adbus;
  logic [DATA-1:0] ram_a_data_in, ram_a_data_out, ram_b_data_in, ram_b_data_out;
  logic            op_valid, op_ready, res_valid, res_ready;
  logic [DATA-1:0] op_x, op_y, res_data;
  logic            done, err;

  modport master (
    input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, ram_a_data_out, ram_b_data_out,
           op_ready, res_valid, res_data,
    output cmd_ready, ram_a_w, ram_a_adbus, ram_a_data_in, ram_b_w, ram_b_adbus,
           ram_b_data_in, op_valid, op_x, op_y, res_ready, done, err
  );

  modport slave (
    output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, ram_a_data_out, ram_b_data_out,
           op_ready, res_valid, res_data,
    input  cmd_ready, ram_a_w, ram_a_adbus, ram_a_data_in, ram_b_w, ram_b_adbus,
           ram_b_data_in, op_valid, op_x, op_y, res_ready, done, err
  );
endinterface

// File: rtl/ram_operand_sequencer.sv
// Single-command sequencer: read two operands from the dual-port RAM, hand
// them to the field multiplier, collect the result and write it back on port A.
module ram_operand_sequencer
  import ram_operand_sequencer_pkg::*;
#(
  parameter int DATA  = DATA_W,
  parameter int ADDR  = ADDR_W,
  parameter int DEPTH = DEPTH_N
) (
  input  logic clk,
  input  logic rst,
  ram_operand_sequencer_if.master bus
);

  state_e          r_state, w_next;
  logic [ADDR-1:0] r_src_a, r_src_b, r_dst, r_a_ad, r_b_ad;
  logic [ADDR-1:0] w_a_ad, w_b_ad;
  logic [DATA-1:0] r_op_x, r_op_y, r_res;
  logic            w_bad;

  assign w_bad = !addr_ok(int'(bus.cmd_src_a), DEPTH) ||
                 !addr_ok(int'(bus.cmd_src_b), DEPTH) ||
                 !addr_ok(int'(bus.cmd_dst),   DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_next = w_bad ? S_ERR : S_RD;
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = S_ISSUE;
      S_ISSUE: if (bus.op_ready) w_next = S_WAIT;
      S_WAIT:  if (bus.res_valid) w_next = S_WB;
      S_WB:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Addresses are only steered in RD/WB; otherwise they hold the last value driven.
  always_comb begin
    w_a_ad = r_a_ad;
    w_b_ad = r_b_ad;
    case (r_state)
      S_RD: begin w_a_ad = r_src_a; w_b_ad = r_src_b; end
      S_WB: w_a_ad = r_dst;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_a <= '0; r_src_b <= '0; r_dst <= '0;
      r_a_ad  <= '0; r_b_ad  <= '0;
      r_op_x  <= '0; r_op_y  <= '0; r_res <= '0;
    end else begin
      if (r_state == S_IDLE && bus.cmd_valid) begin
        r_src_a <= bus.cmd_src_a;
        r_src_b <= bus.cmd_src_b;
        r_dst   <= bus.cmd_dst;
      end
      // RAM read data lands one cycle after RD, i.e. during CAP.
      if (r_state == S_CAP) begin
        r_op_x <= bus.ram_a_data_out;
        r_op_y <= bus.ram_b_data_out;
      end
      if (r_state == S_WAIT && bus.res_valid) r_res <= bus.res_data;
      r_a_ad <= w_a_ad;
      r_b_ad <= w_b_ad;
    end
  end

  assign bus.cmd_ready     = (r_state == S_IDLE) && !rst;
  assign bus.ram_a_w       = (r_state == S_WB);
  assign bus.ram_a_adbus   = w_a_ad;
  assign bus.ram_a_data_in = r_res;
  assign bus.ram_b_w       = 1'b0;
  assign bus.ram_b_adbus   = w_b_ad;
  assign bus.ram_b_data_in = '0;
  assign bus.op_valid      = (r_state == S_ISSUE);
  assign bus.op_x          = r_op_x;
  assign bus.op_y          = r_op_y;
  assign bus.res_ready     = (r_state == S_WAIT);
  assign bus.done          = (r_state == S_DONE);
  assign bus.err           = (r_state == S_ERR);

endmodule
